// File: rtl/dlfloat16_to_int32.sv
// DLFloat16 -> signed int32 converter: two-stage valid/ready pipeline (decode, convert).
// Optional macro ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module dlfloat16_to_int32 #(
  parameter logic [3:0] ENA_CODE = 4'b1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  ena,
  input  logic [15:0] in_float,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic [4:0]  exceptions
);

  localparam int EXP_BIAS = 31;

  logic              advance_s;
  logic              in_ready_s;
  logic [5:0]        dec_exp_s;
  logic [8:0]        dec_mant_s;
  logic signed [6:0] dec_e_s;

  logic              s1_valid_r;
  logic              s1_sign_r;
  logic signed [6:0] s1_exp_r;
  logic [9:0]        s1_sig_r;
  logic              s1_zero_r;
  logic              s1_nan_r;
  logic              s1_normal_r;
  logic              s1_hit_r;

  logic [31:0]       mag_s;
  logic [19:0]       ext_s;
  logic              guard_s;
  logic              sticky_s;
  logic              sat_s;
  logic              inv_s;
  logic              ovf_s;
  logic              inexact_s;
  logic              unf_s;
  logic [31:0]       res_s;
  logic [4:0]        flags_s;
`ifdef ROUND_NEAREST_EN
  logic              round_up_s;
`endif

  logic              out_valid_r;
  logic [31:0]       int_out_r;
  logic [4:0]        exc_r;

  assign advance_s  = !out_valid_r || out_ready;
  assign in_ready_s = advance_s || !s1_valid_r;
  assign in_ready   = in_ready_s;

  assign dec_exp_s  = in_float[14:9];
  assign dec_mant_s = in_float[8:0];
  assign dec_e_s    = $signed({1'b0, dec_exp_s}) - $signed(7'(EXP_BIAS));

  // Stage 1: latch decoded operand fields on input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_sign_r   <= 1'b0;
      s1_exp_r    <= 7'sd0;
      s1_sig_r    <= 10'd0;
      s1_zero_r   <= 1'b0;
      s1_nan_r    <= 1'b0;
      s1_normal_r <= 1'b0;
      s1_hit_r    <= 1'b0;
    end else if (in_ready_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sign_r   <= in_float[15];
        s1_exp_r    <= dec_e_s;
        s1_sig_r    <= {1'b1, dec_mant_s};
        s1_zero_r   <= (dec_exp_s == 6'd0);
        s1_nan_r    <= (dec_exp_s == 6'd63) && (dec_mant_s == 9'd511);
        s1_normal_r <= (dec_exp_s != 6'd0) &&
                       !((dec_exp_s == 6'd63) && (dec_mant_s == 9'd511));
        s1_hit_r    <= (ena == ENA_CODE);
      end
    end
  end

  // Stage 2 datapath: magnitude, rounding, sign and exception flags
  always_comb begin
    mag_s     = 32'd0;
    ext_s     = 20'd0;
    guard_s   = 1'b0;
    sticky_s  = 1'b0;
    sat_s     = 1'b0;
    inv_s     = 1'b0;
    ovf_s     = 1'b0;
    inexact_s = 1'b0;
    unf_s     = 1'b0;
    res_s     = 32'd0;
    flags_s   = 5'd0;
`ifdef ROUND_NEAREST_EN
    round_up_s = 1'b0;
`endif
    if (s1_zero_r) begin
      mag_s = 32'd0;
    end else if (s1_nan_r) begin
      inv_s = 1'b1;
      sat_s = 1'b1;
    end else if (s1_exp_r >= 7'sd31) begin
      // -2^31 is the one representable value at e=31
      if (s1_sign_r && (s1_exp_r == 7'sd31) && (s1_sig_r[8:0] == 9'd0)) begin
        mag_s = 32'h8000_0000;
      end else begin
        ovf_s = 1'b1;
        sat_s = 1'b1;
      end
    end else if (s1_exp_r >= 7'sd9) begin
      mag_s = {22'd0, s1_sig_r} << (s1_exp_r[4:0] - 5'd9);
    end else if (s1_exp_r >= -7'sd1) begin
      // e=-1 wraps the 5-bit amount to 10, leaving the whole significand as fraction
      ext_s    = {s1_sig_r, 10'd0} >> (5'd9 - s1_exp_r[4:0]);
      guard_s  = ext_s[9];
      sticky_s = |ext_s[8:0];
`ifdef ROUND_NEAREST_EN
      round_up_s = guard_s && (sticky_s || ext_s[10]);
      mag_s      = {22'd0, ext_s[19:10]} + {31'd0, round_up_s};
`else
      mag_s      = {22'd0, ext_s[19:10]};
`endif
    end else begin
      sticky_s = 1'b1;
    end

    inexact_s = guard_s || sticky_s;

    if (sat_s) begin
      res_s = s1_sign_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      res_s = s1_sign_r ? (32'd0 - mag_s) : mag_s;
    end

    unf_s = s1_normal_r && !sat_s && (res_s == 32'd0);

    if (s1_hit_r) begin
      flags_s = {inv_s, inexact_s, ovf_s, unf_s, 1'b0};
    end else begin
      res_s   = 32'd0;
      flags_s = 5'd0;
    end
  end

  // Stage 2 register: result and flags advance when downstream can take them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      int_out_r   <= 32'd0;
      exc_r       <= 5'd0;
    end else if (advance_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        int_out_r <= res_s;
        exc_r     <= flags_s;
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign int_out    = int_out_r;
  assign exceptions = exc_r;

endmodule

// File: tb/tb_dlfloat16_to_int32.sv
// Scoreboard bench for dlfloat16_to_int32: directed vectors, stall and async-reset scenarios.
module tb_dlfloat16_to_int32;

  localparam logic [3:0] ENA   = 4'b1000;
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_INV  = 5'b10000;
  localparam logic [4:0] F_INX  = 5'b01000;
  localparam logic [4:0] F_OVF  = 5'b00100;
  localparam logic [4:0] F_UNF  = 5'b01010;
  localparam int BUDGET = 50;

`ifdef ROUND_NEAREST_EN
  localparam logic [31:0] R_3P5  = 32'd4;
  localparam logic [31:0] R_M3P5 = 32'hFFFF_FFFC;
  localparam logic [31:0] R_4FFF = 32'd512;
  localparam logic [31:0] R_3C01 = 32'd1;
  localparam logic [4:0]  F_3C01 = F_INX;
`else
  localparam logic [31:0] R_3P5  = 32'd3;
  localparam logic [31:0] R_M3P5 = 32'hFFFF_FFFD;
  localparam logic [31:0] R_4FFF = 32'd511;
  localparam logic [31:0] R_3C01 = 32'd0;
  localparam logic [4:0]  F_3C01 = F_UNF;
`endif

  typedef struct packed {
    logic [15:0] din;
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ena;
  logic [15:0] in_float;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic [4:0]  exceptions;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        held = 1'b0;
  logic [31:0] held_int;
  logic [4:0]  held_exc;

  dlfloat16_to_int32 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ena(ena), .in_float(in_float), .out_valid(out_valid), .out_ready(out_ready),
    .int_out(int_out), .exceptions(exceptions)
  );

  always #5 clk = ~clk;

  // Monitor: pops the scoreboard on each output transfer and checks stall stability
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got int_out=%h exc=%b with empty scoreboard", int_out, exceptions);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (int_out !== e.res || exceptions !== e.flg) begin
            failures++;
            $display("FAIL result_%h: got int_out=%h exc=%b, expected int_out=%h exc=%b",
                     e.din, int_out, exceptions, e.res, e.flg);
          end
        end
        held = 1'b0;
      end else begin
        if (held) begin
          checks++;
          if (int_out !== held_int || exceptions !== held_exc) begin
            failures++;
            $display("FAIL stall_hold: got int_out=%h exc=%b, expected held int_out=%h exc=%b",
                     int_out, exceptions, held_int, held_exc);
          end
        end
        held     = 1'b1;
        held_int = int_out;
        held_exc = exceptions;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic send(input logic [15:0] din, input logic [3:0] op,
                      input logic [31:0] res, input logic [4:0] flg);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_float = din;
    ena      = op;
    for (int c = 0; c < BUDGET && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{din: din, res: res, flg: flg});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      failures++;
      $display("FAIL accept_timeout_%h: in_ready never high within %0d cycles", din, BUDGET);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_float  = 16'd0;
    ena       = 4'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check1("reset_outputs", {out_valid, int_out, exceptions}, 38'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check1("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Latency from accept to out_valid, then directed vectors back to back
    out_ready = 1'b1;
    send(16'h3E00, ENA, 32'h0000_0001, F_NONE);
    check1("latency_stage1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check1("latency_stage2", {31'd0, out_valid}, 32'd1);
    send(16'hBE00, ENA, 32'hFFFF_FFFF, F_NONE);
    send(16'h4300, ENA, 32'h0000_0006, F_NONE);
    send(16'h4080, ENA, 32'h0000_0002, F_INX);
    send(16'h4180, ENA, R_3P5,         F_INX);
    send(16'hC180, ENA, R_M3P5,        F_INX);
    send(16'hFC00, ENA, 32'h8000_0000, F_NONE);
    send(16'h7C00, ENA, 32'h7FFF_FFFF, F_OVF);
    send(16'h7FFF, ENA, 32'h7FFF_FFFF, F_INV);
    send(16'hFFFF, ENA, 32'h8000_0000, F_INV);
    send(16'h3C00, ENA, 32'h0000_0000, F_UNF);
    send(16'hBC00, ENA, 32'h0000_0000, F_UNF);
    send(16'h0000, ENA, 32'h0000_0000, F_NONE);
    send(16'h01FF, ENA, 32'h0000_0000, F_NONE);
    send(16'h8000, ENA, 32'h0000_0000, F_NONE);
    send(16'h4300, 4'b0111, 32'h0000_0000, F_NONE);
    send(16'h7A00, ENA, 32'h4000_0000, F_NONE);
    send(16'h7BFF, ENA, 32'h7FE0_0000, F_NONE);
    send(16'hFBFF, ENA, 32'h8020_0000, F_NONE);
    send(16'hFE00, ENA, 32'h8000_0000, F_OVF);
    send(16'h5000, ENA, 32'h0000_0200, F_NONE);
    send(16'h4FFF, ENA, R_4FFF,        F_INX);
    send(16'h3A00, ENA, 32'h0000_0000, F_UNF);
    send(16'h3C01, ENA, R_3C01,        F_3C01);
    drain();

    // Stall: two accepted, then in_ready drops until out_ready returns
    out_ready = 1'b0;
    send(16'h4300, ENA, 32'h0000_0006, F_NONE);
    send(16'h4080, ENA, 32'h0000_0002, F_INX);
    check1("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
    fork
      begin
        send(16'hBE00, ENA, 32'hFFFF_FFFF, F_NONE);
        send(16'h7A00, ENA, 32'h4000_0000, F_NONE);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two items in flight
    send(16'h4300, ENA, 32'h0000_0006, F_NONE);
    send(16'h7A00, ENA, 32'h4000_0000, F_NONE);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check1("async_reset_outputs", {out_valid, int_out, exceptions}, 38'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check1("no_stale_after_reset", {31'd0, out_valid}, 32'd0);
    end
    send(16'hC180, ENA, R_M3P5, F_INX);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
